icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the fetch/instruction-queue logic and the memory controller's instruction port.
- Serves 32-bit instruction fetches by PC.
- On a miss, issues a single 4-byte read request on the controller's instruction channel and waits for the ready pulse. It then fills the line and returns the word.
- Flushable in-flight state on `clear` (branch mispredict); cached contents survive `clear`.

Parameters:
- IDX_W, 4, index bits; cache holds 2^IDX_W one-word lines.
- TAG_W, 30-IDX_W (derived, localparam), tag bits = PC[31:2+IDX_W].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state frozen
- clear  in  1  flush in-flight fetch (mispredict)
- fetch_req  in  1  fetch request strobe, sampled only when fetch_busy=0
- fetch_pc  in  32  byte address of instruction, low 2 bits must be 0
- fetch_busy  out  1  cache cannot accept a request this cycle
- ins_valid  out  1  one-cycle pulse: ins_data/ins_pc valid
- ins_data  out  32  returned instruction
- ins_pc  out  32  PC of returned instruction
- mem_req  out  1  one-cycle request pulse to memory controller instruction channel
- mem_addr  out  32  start byte address of request
- mem_remain  out  4  bytes to read; always 4 when mem_req=1
- mem_ready  in  1  controller pulse: mem_data holds the completed word
- mem_data  in  32  little-endian assembled instruction word

Behaviour:
- Reset (rst=1 at posedge):
  - State IDLE; all line valid bits cleared.
  - Outputs: fetch_busy=0, ins_valid=0, ins_data=0, ins_pc=0, mem_req=0, mem_addr=0, mem_remain=0.
  - rst has priority over rdy and clear.
- rdy=0: no register updates. Pulse outputs hold their value; the controller is frozen by the same rdy.
- Lookup:
  - idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
  - Hit = valid[idx] && tag_arr[idx]==tag.
- States:
  - IDLE:
    - fetch_busy=0.
    - On fetch_req with a hit: next cycle ins_valid=1, ins_data=data_arr[idx], ins_pc=fetch_pc; stay in IDLE. Hit latency is 1 cycle.
    - On fetch_req with a miss: latch pc into req_pc; next cycle mem_req=1, mem_addr=fetch_pc, mem_remain=4; go to WAIT.
  - WAIT:
    - fetch_busy=1.
    - mem_req deasserts after exactly one cycle; mem_addr and mem_remain hold their values.
    - On mem_ready: write data_arr/tag_arr/valid for req_pc's index; next cycle ins_valid=1, ins_data=mem_data, ins_pc=req_pc; go to IDLE.
    - Miss latency = controller latency + 1.
- ins_valid and mem_req are single-cycle pulses; they are forced to 0 on any cycle that does not set them.
- fetch_busy is combinational from state, so a fetch_req held high during WAIT is ignored. The requester must re-present the request after busy drops.
- Back-to-back hits: one result per cycle, with fetch_busy=0 throughout.
- clear (rdy=1, rst=0):
  - Next state IDLE.
  - ins_valid=0, mem_req=0.
  - A fetch_req in the same cycle is dropped (clear wins).
  - A mem_ready in the same cycle is dropped; no line is written.
  - Line contents and valid bits are unchanged.
- mem_ready in IDLE (stale, after clear): ignored, no write.
- Refill replaces the line unconditionally (no replacement policy; direct-mapped).
- No self-modifying-code coherence; stores never invalidate lines.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch_req with pc=0x00000010; model returns mem_ready with mem_data=0x00A00093 five cycles after mem_req.
  - Required: mem_req one cycle with mem_addr=0x10, mem_remain=4; fetch_busy=1 until return.
  - Required: ins_valid one cycle after mem_ready with ins_data=0x00A00093, ins_pc=0x10.
- Hit:
  - Stimulus: repeat pc=0x10.
  - Required: ins_valid next cycle, data 0x00A00093, no mem_req.
  - Stimulus: then pc=0x10 and 0x10 on consecutive cycles.
  - Required: two consecutive ins_valid pulses.
- Conflict eviction (IDX_W=4):
  - Stimulus: fill pc=0x04, then pc=0x44 (same index 1, different tag) returning 0x11111111, then fetch 0x04 again.
  - Required: 0x44 causes a miss; the re-fetch of 0x04 misses again and issues mem_req with mem_addr=0x04.
- Clear mid-miss:
  - Stimulus: miss on pc=0x20, assert clear two cycles later, then late mem_ready with data 0xDEADBEEF.
  - Required: no ins_valid; a subsequent fetch of 0x20 still misses (no write occurred).
- Simultaneous clear and fetch_req with a hit address:
  - Required: no ins_valid; fetch_busy=0 next cycle.
- rdy stall:
  - Stimulus: drop rdy for 3 cycles while in WAIT, pulsing mem_ready only after rdy returns.
  - Required: state and mem_addr unchanged during the stall; normal completion afterwards.
- Reset mid-WAIT:
  - Required: IDLE, all outputs 0, previously cached pc=0x10 now misses.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped one-word-per-line instruction cache in front of the memory
// controller's instruction channel. One outstanding miss; clear drops it.
module icache_fetch #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_busy,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_remain,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    localparam int TAG_W = 30 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state;
    logic [31:0]        req_pc;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [31:0]        data_arr [LINES];

    logic [IDX_W-1:0]   f_idx, r_idx;
    logic [TAG_W-1:0]   f_tag, r_tag;
    logic               hit;
    logic               fill;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign r_idx = req_pc[IDX_W+1:2];
    assign r_tag = req_pc[31:IDX_W+2];
    assign hit   = valid[f_idx] && (tag_arr[f_idx] == f_tag);

    // A return coinciding with clear (or arriving while idle) must not touch the line.
    assign fill  = !rst && rdy && !clear && (state == S_WAIT) && mem_ready;

    assign fetch_busy = (state == S_WAIT);

    // Line storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[r_idx] <= mem_data;
            tag_arr[r_idx]  <= r_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_pc     <= '0;
            valid      <= '0;
            ins_valid  <= 1'b0;
            ins_data   <= '0;
            ins_pc     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_remain <= '0;
        end else if (rdy) begin
            ins_valid <= 1'b0;
            mem_req   <= 1'b0;
            if (clear) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fetch_req) begin
                            if (hit) begin
                                ins_valid <= 1'b1;
                                ins_data  <= data_arr[f_idx];
                                ins_pc    <= fetch_pc;
                            end else begin
                                req_pc     <= fetch_pc;
                                mem_req    <= 1'b1;
                                mem_addr   <= fetch_pc;
                                mem_remain <= 4'd4;
                                state      <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (mem_ready) begin
                            valid[r_idx] <= 1'b1;
                            ins_valid    <= 1'b1;
                            ins_data     <= mem_data;
                            ins_pc       <= req_pc;
                            state        <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: a pc->line map models the cache, a
// monitor pops expected instruction returns and memory requests.
module tb_icache_fetch;
    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, fetch_req, mem_ready;
    logic [31:0] fetch_pc, mem_data;
    logic        fetch_busy, ins_valid, mem_req;
    logic [31:0] ins_data, ins_pc, mem_addr;
    logic [3:0]  mem_remain;

    icache_fetch #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_busy(fetch_busy),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_remain(mem_remain),
        .mem_ready(mem_ready), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ins_t;

    int          checks = 0;
    int          errors = 0;
    ins_t        exp_ins [$];
    logic [31:0] exp_mem [$];
    logic [31:0] line_pc  [int];
    logic [31:0] line_dat [int];
    logic [31:0] mem_ovr  [logic [31:0]];
    ins_t        mon_e;
    logic [31:0] mon_a;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return line_pc.exists(idx_of(pc)) && line_pc[idx_of(pc)] == pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (ins_valid) begin
                if (exp_ins.size() == 0) check("ins_unexpected", 32'(ins_valid), 32'd0);
                else begin
                    mon_e = exp_ins.pop_front();
                    check("ins_pc", ins_pc, mon_e.pc);
                    check("ins_data", ins_data, mon_e.data);
                end
            end
            if (mem_req) begin
                if (exp_mem.size() == 0) check("mem_req_unexpected", 32'(mem_req), 32'd0);
                else begin
                    mon_a = exp_mem.pop_front();
                    check("mem_addr", mem_addr, mon_a);
                    check("mem_remain", 32'(mem_remain), 32'd4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy && n < 20) begin
            tick();
            n++;
        end
        if (fetch_busy) check("busy_timeout", 32'(fetch_busy), 32'd0);
    endtask

    // Full fetch transaction, answering a miss after lat cycles.
    task automatic fetch(input logic [31:0] pc, input int lat);
        bit hit;
        wait_idle();
        hit = model_hit(pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        if (hit) exp_ins.push_back('{pc, line_dat[idx_of(pc)]});
        else     exp_mem.push_back(pc);
        tick();
        fetch_req = 1'b0;
        if (hit) begin
            check("hit_latency", 32'(ins_valid), 32'd1);
            check("hit_no_busy", 32'(fetch_busy), 32'd0);
        end else begin
            check("miss_req", 32'(mem_req), 32'd1);
            check("miss_busy", 32'(fetch_busy), 32'd1);
            repeat (lat - 1) begin
                tick();
                check("wait_busy", 32'(fetch_busy), 32'd1);
                check("wait_addr_hold", mem_addr, pc);
            end
            mem_ready = 1'b1;
            mem_data  = mem_word(pc);
            exp_ins.push_back('{pc, mem_word(pc)});
            line_pc[idx_of(pc)]  = pc;
            line_dat[idx_of(pc)] = mem_word(pc);
            tick();
            mem_ready = 1'b0;
            mem_data  = $urandom;
            check("fill_latency", 32'(ins_valid), 32'd1);
            check("busy_drop", 32'(fetch_busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; fetch_req = 1'b0;
        fetch_pc = '0; mem_ready = 1'b0; mem_data = '0;
        mem_ovr[32'h10] = 32'h00A00093;
        mem_ovr[32'h44] = 32'h11111111;
        tick(); tick();
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss, then hit, then back-to-back hits.
        fetch(32'h10, 5);
        fetch(32'h10, 1);
        wait_idle();
        fetch_req = 1'b1; fetch_pc = 32'h10;
        exp_ins.push_back('{32'h10, 32'h00A00093});
        exp_ins.push_back('{32'h10, 32'h00A00093});
        tick();
        check("b2b_first", 32'(ins_valid), 32'd1);
        check("b2b_busy", 32'(fetch_busy), 32'd0);
        tick();
        fetch_req = 1'b0;
        check("b2b_second", 32'(ins_valid), 32'd1);
        tick();

        // Conflict eviction on index 1.
        fetch(32'h04, 2);
        fetch(32'h44, 3);
        fetch(32'h04, 2);

        // Clear mid-miss, stale return afterwards.
        fetch_req = 1'b1; fetch_pc = 32'h20;
        exp_mem.push_back(32'h20);
        tick();
        fetch_req = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", 32'(fetch_busy), 32'd0);
        tick(); tick();
        mem_ready = 1'b1; mem_data = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        check("stale_ready_no_ins", 32'(ins_valid), 32'd0);
        fetch(32'h20, 3);

        // Clear coinciding with the return: dropped, no write.
        fetch_req = 1'b1; fetch_pc = 32'h30;
        exp_mem.push_back(32'h30);
        tick();
        fetch_req = 1'b0;
        clear = 1'b1; mem_ready = 1'b1; mem_data = 32'hCAFEF00D;
        tick();
        clear = 1'b0; mem_ready = 1'b0;
        check("clear_ready_no_ins", 32'(ins_valid), 32'd0);
        fetch(32'h30, 2);

        // Clear with a hitting fetch: clear wins.
        fetch_req = 1'b1; clear = 1'b1; fetch_pc = 32'h10;
        tick();
        fetch_req = 1'b0; clear = 1'b0;
        check("clear_hit_no_ins", 32'(ins_valid), 32'd0);
        check("clear_hit_busy", 32'(fetch_busy), 32'd0);

        // rdy stall in WAIT.
        fetch_req = 1'b1; fetch_pc = 32'h60;
        exp_mem.push_back(32'h60);
        tick();
        fetch_req = 1'b0;
        tick();
        rdy = 1'b0;
        repeat (3) begin
            tick();
            check("stall_busy", 32'(fetch_busy), 32'd1);
            check("stall_addr", mem_addr, 32'h60);
            check("stall_remain", 32'(mem_remain), 32'd4);
        end
        rdy = 1'b1;
        tick();
        mem_ready = 1'b1; mem_data = mem_word(32'h60);
        exp_ins.push_back('{32'h60, mem_word(32'h60)});
        line_pc[idx_of(32'h60)]  = 32'h60;
        line_dat[idx_of(32'h60)] = mem_word(32'h60);
        tick();
        mem_ready = 1'b0;
        check("stall_fill", 32'(ins_valid), 32'd1);

        // Reset mid-WAIT invalidates everything.
        fetch_req = 1'b1; fetch_pc = 32'h80;
        exp_mem.push_back(32'h80);
        tick();
        fetch_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        line_pc.delete();
        line_dat.delete();
        check("rst2_busy", 32'(fetch_busy), 32'd0);
        check("rst2_ins_valid", 32'(ins_valid), 32'd0);
        check("rst2_ins_data", ins_data, 32'd0);
        check("rst2_ins_pc", ins_pc, 32'd0);
        check("rst2_mem_req", 32'(mem_req), 32'd0);
        check("rst2_mem_addr", mem_addr, 32'd0);
        check("rst2_mem_remain", 32'(mem_remain), 32'd0);
        fetch(32'h10, 2);

        // Random traffic over a small footprint to force hits and conflicts.
        for (int i = 0; i < 80; i++) begin
            fetch({24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(1, 5));
            if ($urandom_range(0, 3) == 0) tick();
        end

        tick(); tick();
        check("ins_queue_drained", exp_ins.size(), 32'd0);
        check("mem_queue_drained", exp_mem.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
